// File: rtl/lock_seq_pkg.sv
// rtl/lock_seq_pkg.sv - state encoding and default widths shared by lock_sequencer
package lock_seq_pkg;
   localparam int LS_DATA_WIDTH = 14;
   localparam int LS_CNT_WIDTH  = 16;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SWEEP   = 3'd1,
      S_CAPTURE = 3'd2,
      S_LOCKED  = 3'd3,
      S_LOST    = 3'd4,
      S_FAULT   = 3'd5
   } lock_state_t;
endpackage

// File: rtl/sweep_gen.sv
// rtl/sweep_gen.sv - triangle ramp between signed bounds; load/advance/hold driven by the sequencer
module sweep_gen
   import lock_seq_pkg::*;
#(
   parameter int DATA_WIDTH = LS_DATA_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_load,
   input  logic                         i_advance,
   input  logic signed [DATA_WIDTH-1:0] i_min,
   input  logic signed [DATA_WIDTH-1:0] i_max,
   input  logic        [DATA_WIDTH-1:0] i_step,
   output logic signed [DATA_WIDTH-1:0] o_value
);
   // Two guard bits: a full-range unsigned step added to a signed value cannot wrap.
   localparam int EW = DATA_WIDTH + 2;

   logic signed [DATA_WIDTH-1:0] r_value;
   logic                         r_down;
   logic signed [EW-1:0]         w_cur;
   logic signed [EW-1:0]         w_min;
   logic signed [EW-1:0]         w_max;
   logic signed [EW-1:0]         w_step;
   logic signed [EW-1:0]         w_up;
   logic signed [EW-1:0]         w_dn;

   assign w_cur  = {{2{r_value[DATA_WIDTH-1]}}, r_value};
   assign w_min  = {{2{i_min[DATA_WIDTH-1]}}, i_min};
   assign w_max  = {{2{i_max[DATA_WIDTH-1]}}, i_max};
   assign w_step = {2'b00, i_step};
   assign w_up   = w_cur + w_step;
   assign w_dn   = w_cur - w_step;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_value <= '0;
         r_down  <= 1'b0;
      end else if (i_load) begin
         r_value <= i_min;
         r_down  <= 1'b0;
      end else if (i_advance) begin
         if (i_min > i_max) begin
            r_value <= i_min;
         end else if (!r_down) begin
            if (w_up >= w_max) begin
               r_value <= i_max;
               r_down  <= 1'b1;
            end else begin
               r_value <= w_up[DATA_WIDTH-1:0];
            end
         end else begin
            if (w_dn <= w_min) begin
               r_value <= i_min;
               r_down  <= 1'b0;
            end else begin
               r_value <= w_dn[DATA_WIDTH-1:0];
            end
         end
      end
   end

   assign o_value = r_value;
endmodule

// File: rtl/lock_sequencer.sv
// rtl/lock_sequencer.sv - sweep/capture/lock sequencer for a PID loop
// LOCK_SEQ_RELOCK_EN: LOST re-enters SWEEP and counts relocks; otherwise LOST ends in FAULT.
module lock_sequencer
   import lock_seq_pkg::*;
#(
   parameter int DATA_WIDTH = LS_DATA_WIDTH,
   parameter int CNT_WIDTH  = LS_CNT_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic signed [DATA_WIDTH-1:0] loop_input,
   input  logic signed [DATA_WIDTH-1:0] threshold,
   input  logic signed [DATA_WIDTH-1:0] sweep_min,
   input  logic signed [DATA_WIDTH-1:0] sweep_max,
   input  logic        [DATA_WIDTH-1:0] sweep_step,
   input  logic signed [DATA_WIDTH-1:0] error,
   input  logic        [DATA_WIDTH-1:0] error_tol,
   input  logic        [CNT_WIDTH-1:0]  lost_cycles,
   output logic                         pid_rst,
   output logic signed [DATA_WIDTH-1:0] i_term_preload,
   output logic signed [DATA_WIDTH-1:0] sweep_out,
   output logic                         use_pid,
   output logic                         locked,
   output logic        [2:0]            state,
   output logic        [7:0]            relock_count
);
   lock_state_t                  r_state;
   lock_state_t                  w_next;
   logic                         r_hit;
   logic [CNT_WIDTH-1:0]         r_cnt;
   logic [CNT_WIDTH-1:0]         w_cnt_next;
   logic                         r_pid_rst;
   logic                         r_locked;
   logic signed [DATA_WIDTH-1:0] r_preload;
   logic                         w_hit;
   logic                         w_over;
   logic                         w_loss;
   logic                         w_load;
   logic                         w_advance;
   logic signed [DATA_WIDTH:0]   w_err_ext;
   logic        [DATA_WIDTH:0]   w_abs_err;

   assign w_hit      = loop_input >= threshold;
   assign w_err_ext  = {error[DATA_WIDTH-1], error};
   assign w_abs_err  = error[DATA_WIDTH-1] ? -w_err_ext : w_err_ext;
   assign w_over     = w_abs_err > {1'b0, error_tol};
   assign w_cnt_next = !w_over ? '0 : ((&r_cnt) ? r_cnt : r_cnt + 1'b1);
   assign w_loss     = (lost_cycles != '0) && (w_cnt_next >= lost_cycles);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (enable) w_next = S_SWEEP;
         S_SWEEP:   if (w_hit && r_hit) w_next = S_CAPTURE;
         S_CAPTURE: w_next = S_LOCKED;
         S_LOCKED:  if (w_loss) w_next = S_LOST;
`ifdef LOCK_SEQ_RELOCK_EN
         S_LOST:    w_next = S_SWEEP;
`else
         S_LOST:    w_next = S_FAULT;
`endif
         S_FAULT:   w_next = S_FAULT;
         default:   w_next = S_IDLE;
      endcase
      if (!enable) w_next = S_IDLE;
   end

   // Ramp only moves while staying in SWEEP, so it freezes at the capture point and resumes from it.
   assign w_load    = (r_state == S_IDLE) || (w_next == S_IDLE);
   assign w_advance = (r_state == S_SWEEP) && (w_next == S_SWEEP);

   sweep_gen #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_sweep (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_load),
      .i_advance (w_advance),
      .i_min     (sweep_min),
      .i_max     (sweep_max),
      .i_step    (sweep_step),
      .o_value   (sweep_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_hit     <= 1'b0;
         r_cnt     <= '0;
         r_pid_rst <= 1'b1;
         r_locked  <= 1'b0;
         r_preload <= '0;
      end else begin
         r_state   <= w_next;
         r_hit     <= (r_state == S_SWEEP) && w_hit;
         r_cnt     <= (r_state == S_LOCKED) ? w_cnt_next : '0;
         r_pid_rst <= (w_next != S_LOCKED);
         r_locked  <= (w_next == S_LOCKED);
         if (w_next == S_CAPTURE) r_preload <= sweep_out;
      end
   end

`ifdef LOCK_SEQ_RELOCK_EN
   logic [7:0] r_relock;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_relock <= '0;
      end else if ((w_next == S_LOST) && (r_relock != 8'hFF)) begin
         r_relock <= r_relock + 1'b1;
      end
   end

   assign relock_count = r_relock;
`else
   assign relock_count = 8'd0;
`endif

   assign pid_rst        = r_pid_rst;
   assign use_pid        = r_locked;
   assign locked         = r_locked;
   assign i_term_preload = r_preload;
   assign state          = r_state;
endmodule

// File: tb/tb_lock_sequencer.sv
// tb/tb_lock_sequencer.sv - randomized self-checking bench for lock_sequencer
module tb_lock_sequencer;
   localparam int DW = 14;
   localparam int CW = 16;
   localparam logic [2:0] IDLE = 3'd0, SWEEP = 3'd1, CAPTURE = 3'd2,
                          LOCKED = 3'd3, LOST = 3'd4, FAULT = 3'd5;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 enable;
   logic signed [DW-1:0] loop_input, threshold, sweep_min, sweep_max, error;
   logic        [DW-1:0] sweep_step, error_tol;
   logic        [CW-1:0] lost_cycles;
   logic                 pid_rst, use_pid, locked;
   logic signed [DW-1:0] i_term_preload, sweep_out;
   logic        [2:0]    state;
   logic        [7:0]    relock_count;

   int n_tests = 0;
   int n_fail  = 0;
   int m_pos;
   bit m_up;

   lock_sequencer dut (
      .clk(clk), .rst(rst), .enable(enable), .loop_input(loop_input), .threshold(threshold),
      .sweep_min(sweep_min), .sweep_max(sweep_max), .sweep_step(sweep_step), .error(error),
      .error_tol(error_tol), .lost_cycles(lost_cycles), .pid_rst(pid_rst),
      .i_term_preload(i_term_preload), .sweep_out(sweep_out), .use_pid(use_pid),
      .locked(locked), .state(state), .relock_count(relock_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Triangle ramp reference: step toward the active bound, clamp on reaching it and turn around.
   function automatic void model_advance(int mn, int mx, int st);
      int n;
      if (mn > mx) begin
         m_pos = mn;
      end else if (m_up) begin
         n = m_pos + st;
         if (n >= mx) begin m_pos = mx; m_up = 0; end else m_pos = n;
      end else begin
         n = m_pos - st;
         if (n <= mn) begin m_pos = mn; m_up = 1; end else m_pos = n;
      end
   endfunction

   task automatic go_idle();
      rst = 1'b0;
      enable = 1'b0;
      tick();
   endtask

   task automatic enter_sweep(int mn, int mx, int st);
      sweep_min  = DW'(mn);
      sweep_max  = DW'(mx);
      sweep_step = DW'(st);
      threshold  = DW'(8191);
      loop_input = DW'(-8192);
      enable     = 1'b1;
      tick();
      m_pos = mn;
      m_up  = 1;
   endtask

   task automatic go_locked(int tol, int lost);
      go_idle();
      error       = '0;
      error_tol   = DW'(tol);
      lost_cycles = CW'(lost);
      sweep_min   = DW'(-100);
      sweep_max   = DW'(100);
      sweep_step  = DW'(50);
      threshold   = DW'(-8192);
      loop_input  = '0;
      enable      = 1'b1;
      repeat (4) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; loop_input = '0; threshold = '0; error = '0;
      sweep_min = DW'(-100); sweep_max = DW'(100); sweep_step = DW'(50);
      error_tol = DW'(10); lost_cycles = CW'(3);
      tick(); tick();
      n_tests++; if (state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state, IDLE); end
      n_tests++; if (pid_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pid_rst: got %b want 1", pid_rst); end
      n_tests++; if (use_pid !== 1'b0) begin n_fail++; $display("FAIL reset_use_pid: got %b want 0", use_pid); end
      n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
      n_tests++; if (sweep_out !== '0) begin n_fail++; $display("FAIL reset_sweep_out: got %0d want 0", sweep_out); end
      n_tests++; if (i_term_preload !== '0) begin n_fail++; $display("FAIL reset_preload: got %0d want 0", i_term_preload); end
      n_tests++; if (relock_count !== 8'd0) begin n_fail++; $display("FAIL reset_relock: got %0d want 0", relock_count); end
      go_idle();
      n_tests++; if (state !== IDLE || sweep_out !== DW'(-100) || pid_rst !== 1'b1) begin
         n_fail++; $display("FAIL idle_hold: state %0d sweep_out %0d pid_rst %b, want 0 -100 1", state, sweep_out, pid_rst);
      end
   endtask

   task automatic test_sweep_pattern();
      int exp_seq[12] = '{-100, -50, 0, 50, 100, 50, 0, -50, -100, -50, 0, 50};
      logic signed [DW-1:0] ev;
      go_idle();
      enter_sweep(-100, 100, 50);
      for (int k = 0; k < 12; k++) begin
         ev = DW'(exp_seq[k]);
         n_tests++;
         if (state !== SWEEP || sweep_out !== ev || pid_rst !== 1'b1 || use_pid !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_pattern[%0d]: state %0d sweep_out %0d pid_rst %b use_pid %b, want 1 %0d 1 0",
                     k, state, sweep_out, pid_rst, use_pid, ev);
         end
         tick();
      end
   endtask

   task automatic test_random_sweep();
      int mn, mx, st, t;
      logic signed [DW-1:0] ev;
      for (int run = 0; run < 6; run++) begin
         go_idle();
         mn = int'($urandom_range(0, 16383)) - 8192;
         mx = int'($urandom_range(0, 16383)) - 8192;
         if (mn > mx) begin t = mn; mn = mx; mx = t; end
         if (run == 1) begin
            mn = int'($urandom_range(0, 8191));
            mx = mn - int'($urandom_range(1, 100));
         end
         if (run == 0) st = 0;
         else if (run == 2) st = int'($urandom_range(8000, 16383));
         else st = int'($urandom_range(1, 2000));
         enter_sweep(mn, mx, st);
         for (int c = 0; c < 30; c++) begin
            ev = DW'(m_pos);
            n_tests++;
            if (state !== SWEEP || sweep_out !== ev) begin
               n_fail++;
               $display("FAIL random_sweep[%0d.%0d]: state %0d sweep_out %0d, want 1 %0d (min %0d max %0d step %0d)",
                        run, c, state, sweep_out, ev, mn, mx, st);
            end
            tick();
            model_advance(mn, mx, st);
         end
      end
   endtask

   task automatic test_capture_glitch();
      int vals[12] = '{-100, -50, 0, 50, 100, 50, 0, -50, -100, -50, 0, 50};
      go_idle();
      error = '0; error_tol = DW'(10); lost_cycles = CW'(3);
      enter_sweep(-100, 100, 50);
      threshold = DW'(1000);
      loop_input = '0;
      for (int k = 0; k < 12; k++) begin
         n_tests++;
         if (state !== SWEEP || sweep_out !== DW'(vals[k])) begin
            n_fail++;
            $display("FAIL capture_wait[%0d]: state %0d sweep_out %0d, want 1 %0d", k, state, sweep_out, vals[k]);
         end
         loop_input = (k == 3 || k == 10 || k == 11) ? DW'(2000) : DW'(0);
         tick();
      end
      loop_input = '0;
      n_tests++;
      if (state !== CAPTURE || i_term_preload !== DW'(50) || sweep_out !== DW'(50) || pid_rst !== 1'b1 || use_pid !== 1'b0) begin
         n_fail++;
         $display("FAIL capture: state %0d preload %0d sweep_out %0d pid_rst %b use_pid %b, want 2 50 50 1 0",
                  state, i_term_preload, sweep_out, pid_rst, use_pid);
      end
      tick();
      n_tests++;
      if (state !== LOCKED || pid_rst !== 1'b0 || use_pid !== 1'b1 || locked !== 1'b1 || sweep_out !== DW'(50)) begin
         n_fail++;
         $display("FAIL locked_entry: state %0d pid_rst %b use_pid %b locked %b sweep_out %0d, want 3 0 1 1 50",
                  state, pid_rst, use_pid, locked, sweep_out);
      end
   endtask

   // Continues from the LOCKED state reached by test_capture_glitch.
   task automatic test_loss_sequence();
      int errs[6] = '{11, 11, 0, 11, 11, 11};
      logic [7:0] exp_relock;
`ifdef LOCK_SEQ_RELOCK_EN
      exp_relock = 8'd1;
`else
      exp_relock = 8'd0;
`endif
      for (int i = 0; i < 6; i++) begin
         error = DW'(errs[i]);
         tick();
         n_tests++;
         if (state !== ((i == 5) ? LOST : LOCKED)) begin
            n_fail++;
            $display("FAIL loss_seq[%0d]: state %0d want %0d", i, state, (i == 5) ? LOST : LOCKED);
         end
      end
      error = '0;
      n_tests++;
      if (pid_rst !== 1'b1 || use_pid !== 1'b0 || locked !== 1'b0 || sweep_out !== DW'(50) || relock_count !== exp_relock) begin
         n_fail++;
         $display("FAIL lost_outputs: pid_rst %b use_pid %b locked %b sweep_out %0d relock %0d, want 1 0 0 50 %0d",
                  pid_rst, use_pid, locked, sweep_out, relock_count, exp_relock);
      end
      tick();
`ifdef LOCK_SEQ_RELOCK_EN
      n_tests++;
      if (state !== SWEEP || sweep_out !== DW'(50) || relock_count !== 8'd1) begin
         n_fail++;
         $display("FAIL relock_resume: state %0d sweep_out %0d relock %0d, want 1 50 1", state, sweep_out, relock_count);
      end
      tick();
      n_tests++;
      if (state !== SWEEP || sweep_out !== DW'(100)) begin
         n_fail++;
         $display("FAIL relock_direction: state %0d sweep_out %0d, want 1 100", state, sweep_out);
      end
`else
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (state !== FAULT || pid_rst !== 1'b1 || use_pid !== 1'b0 || relock_count !== 8'd0) begin
            n_fail++;
            $display("FAIL fault_hold[%0d]: state %0d pid_rst %b use_pid %b relock %0d, want 5 1 0 0",
                     i, state, pid_rst, use_pid, relock_count);
         end
         tick();
      end
      enable = 1'b0;
      tick();
      n_tests++;
      if (state !== IDLE || pid_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL fault_exit: state %0d pid_rst %b, want 0 1", state, pid_rst);
      end
`endif
      go_idle();
   endtask

   task automatic test_min_error();
      go_locked(8191, 1);
      n_tests++; if (state !== LOCKED) begin n_fail++; $display("FAIL minerr_lock: state %0d want 3", state); end
      error = DW'(8191);
      tick();
      n_tests++; if (state !== LOCKED) begin n_fail++; $display("FAIL minerr_in_tol: state %0d want 3", state); end
      error = DW'(-8192);
      tick();
      n_tests++; if (state !== LOST) begin n_fail++; $display("FAIL minerr_lost: state %0d want 4", state); end
      error = '0;
      go_idle();
   endtask

   task automatic test_random_loss();
      int tol, lost, cnt, err, mag;
      bit exp_loss;
      for (int run = 0; run < 8; run++) begin
         tol  = int'($urandom_range(0, 40));
         lost = (run == 0) ? 0 : int'($urandom_range(1, 5));
         go_locked(tol, lost);
         n_tests++; if (state !== LOCKED) begin n_fail++; $display("FAIL rloss_lock[%0d]: state %0d want 3", run, state); end
         cnt = 0;
         for (int c = 0; c < 25; c++) begin
            if ($urandom_range(0, 9) == 0) err = -8192;
            else err = int'($urandom_range(0, 2 * tol + 6)) - (tol + 3);
            error = DW'(err);
            tick();
            mag = (err < 0) ? -err : err;
            cnt = (mag > tol) ? cnt + 1 : 0;
            exp_loss = (lost != 0) && (cnt >= lost);
            n_tests++;
            if (state !== (exp_loss ? LOST : LOCKED)) begin
               n_fail++;
               $display("FAIL rloss[%0d.%0d]: state %0d want %0d (err %0d tol %0d lost %0d)",
                        run, c, state, exp_loss ? LOST : LOCKED, err, tol, lost);
            end
            if (exp_loss) break;
         end
         error = '0;
         go_idle();
      end
   endtask

   task automatic test_enable_drop();
      go_locked(10, 3);
      go_idle();
      enable = 1'b1;
      repeat (3) tick();
      n_tests++; if (state !== CAPTURE) begin n_fail++; $display("FAIL drop_reach_capture: state %0d want 2", state); end
      enable = 1'b0;
      tick();
      n_tests++; if (state !== IDLE || pid_rst !== 1'b1 || use_pid !== 1'b0) begin
         n_fail++; $display("FAIL drop_capture: state %0d pid_rst %b use_pid %b, want 0 1 0", state, pid_rst, use_pid);
      end
      go_locked(10, 3);
      enable = 1'b0;
      tick();
      n_tests++; if (state !== IDLE || pid_rst !== 1'b1 || use_pid !== 1'b0 || locked !== 1'b0) begin
         n_fail++; $display("FAIL drop_locked: state %0d pid_rst %b use_pid %b locked %b, want 0 1 0 0", state, pid_rst, use_pid, locked);
      end
      go_idle();
      enter_sweep(-100, 100, 50);
      tick(); tick();
      n_tests++; if (state !== SWEEP || sweep_out !== DW'(0)) begin
         n_fail++; $display("FAIL rst_sweep_pre: state %0d sweep_out %0d, want 1 0", state, sweep_out);
      end
      rst = 1'b1;
      tick();
      n_tests++; if (state !== IDLE || pid_rst !== 1'b1 || use_pid !== 1'b0 || sweep_out !== '0) begin
         n_fail++; $display("FAIL rst_sweep: state %0d pid_rst %b use_pid %b sweep_out %0d, want 0 1 0 0", state, pid_rst, use_pid, sweep_out);
      end
      go_locked(10, 3);
      rst = 1'b1;
      tick();
      n_tests++; if (state !== IDLE || pid_rst !== 1'b1 || use_pid !== 1'b0) begin
         n_fail++; $display("FAIL rst_locked: state %0d pid_rst %b use_pid %b, want 0 1 0", state, pid_rst, use_pid);
      end
      go_idle();
   endtask

   initial begin
      test_reset();
      test_sweep_pattern();
      test_random_sweep();
      test_capture_glitch();
      test_loss_sequence();
      test_min_error();
      test_random_loss();
      test_enable_drop();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
